// File: rtl/pcap_stream_writer.sv
// Byte-serial to libpcap (little-endian) stream writer: global header once per reset,
// then one store-and-forward record (16-byte header + payload) per input packet.
//
// state | meaning
// GHDR  | emitting the 24-byte global header
// FILL  | accepting packet bytes into the buffer, no output
// RHDR  | emitting the 16-byte record header
// DATA  | emitting buffered payload bytes
module pcap_stream_writer #(
  parameter int MAX_PKT      = 2048,
  parameter int ADDR_W       = 11,
  parameter int LINKTYPE     = 1,
  parameter int TICKS_PER_US = 50
) (
  input  logic       CLOCK,
  input  logic       RESET_N,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  input  logic       pause,
  output logic       datavalid,
  output logic [7:0] data,
  output logic [7:0] pktcount,
  output logic       truncated
);

  typedef enum logic [1:0] {GHDR, FILL, RHDR, DATA} state_t;

  localparam int          PW       = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
  localparam logic [PW-1:0] PRESC_TC = PW'(TICKS_PER_US - 1);
  localparam logic [19:0] USEC_TC  = 20'd999999;
  localparam logic [15:0] MAX_LEN  = 16'(MAX_PKT);
  localparam logic [31:0] SNAPLEN  = 32'(MAX_PKT);
  localparam logic [31:0] LINK     = 32'(LINKTYPE);

  state_t state, state_nxt;

  logic [PW-1:0]     presc;
  logic [19:0]       usec;
  logic [31:0]       sec;
  logic [31:0]       ts_sec;
  logic [19:0]       ts_usec;
  logic [4:0]        idx;
  logic [15:0]       ptr;
  logic [15:0]       len;
  logic [15:0]       incl_len;
  logic [7:0]        mem [0:(2**ADDR_W)-1];
  logic [7:0]        mem_q;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       hdr_word;
  logic [7:0]        cur_byte;
  logic              emit;
  logic              accept;
  logic              wr_en;
  logic              data_done;

  assign accept    = in_valid && in_ready;
  assign wr_en     = accept && (len < MAX_LEN);
  assign incl_len  = (len < MAX_LEN) ? len : MAX_LEN;
  assign data_done = (ptr == (incl_len - 16'd1));

  // Free-running capture clock: prescaler -> microseconds -> seconds.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      presc <= '0;
      usec  <= '0;
      sec   <= '0;
    end else if (presc == PRESC_TC) begin
      presc <= '0;
      if (usec == USEC_TC) begin
        usec <= '0;
        sec  <= sec + 32'd1;
      end else begin
        usec <= usec + 20'd1;
      end
    end else begin
      presc <= presc + PW'(1);
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) state <= GHDR;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      GHDR: if (emit && idx == 5'd23) state_nxt = FILL;
      FILL: if (accept && in_last)    state_nxt = RHDR;
      RHDR: if (emit && idx == 5'd15) state_nxt = DATA;
      DATA: if (emit && data_done)    state_nxt = FILL;
      default: state_nxt = GHDR;
    endcase
  end

  always_comb begin
    in_ready = (state == FILL);
    emit     = (state != FILL) && !pause;
    hdr_word = 32'd0;
    if (state == GHDR) begin
      case (idx[4:2])
        3'd0:    hdr_word = 32'ha1b2c3d4;
        3'd1:    hdr_word = 32'h00040002;
        3'd4:    hdr_word = SNAPLEN;
        3'd5:    hdr_word = LINK;
        default: hdr_word = 32'd0;
      endcase
    end else begin
      case (idx[3:2])
        2'd0:    hdr_word = ts_sec;
        2'd1:    hdr_word = {12'd0, ts_usec};
        2'd2:    hdr_word = {16'd0, incl_len};
        default: hdr_word = {16'd0, len};
      endcase
    end
    cur_byte = (state == DATA) ? mem_q : hdr_word[{idx[1:0], 3'b000} +: 8];
    // Prefetch the next payload byte while the current one is being emitted.
    rd_addr  = (state == DATA && emit) ? ptr[ADDR_W-1:0] + ADDR_W'(1) : ptr[ADDR_W-1:0];
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      datavalid <= 1'b0;
      data      <= 8'd0;
      idx       <= 5'd0;
      ptr       <= 16'd0;
      pktcount  <= 8'd0;
    end else begin
      datavalid <= emit;
      if (emit) begin
        data <= cur_byte;
        idx  <= (state_nxt != state) ? 5'd0 : idx + 5'd1;
      end
      if (state == DATA && emit) begin
        ptr <= data_done ? 16'd0 : ptr + 16'd1;
        if (data_done) pktcount <= pktcount + 8'd1;
      end
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      len       <= 16'd0;
      ts_sec    <= 32'd0;
      ts_usec   <= 20'd0;
      truncated <= 1'b0;
    end else begin
      if (accept) begin
        if (len != 16'hffff) len <= len + 16'd1;
        if (len == 16'd0) begin
          ts_sec  <= sec;
          ts_usec <= usec;
        end
        if (len >= MAX_LEN) truncated <= 1'b1;
      end else if (state == DATA && emit && data_done) begin
        len <= 16'd0;
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (wr_en) mem[len[ADDR_W-1:0]] <= in_data;
    mem_q <= mem[rd_addr];
  end

endmodule
